// File: rtl/imem_line_assembler.sv
// Fetch-side line assembler: turns one line request into four sequential
// memory beat reads and presents the assembled line until fetch takes it.
module imem_line_assembler #(
    parameter int IADDRW = 32,
    parameter int IDATAW = 128,
    parameter int MDATAW = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [IADDRW-1:0] req_address,
    output logic              dp_valid,
    input  logic              dp_ready,
    output logic [IDATAW-1:0] dp_read_data,
    output logic              mem_rd_en,
    input  logic              mem_ready,
    output logic [IADDRW-1:0] mem_address,
    input  logic              mem_rd_valid,
    input  logic [MDATAW-1:0] mem_rd_data,
    output logic              busy
);

    localparam int BEATS      = IDATAW / MDATAW;
    localparam int BEAT_BYTES = MDATAW / 8;
    localparam int SLOTW      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [2:0]        LAST_BEAT = 3'(BEATS - 1);
    localparam logic [IADDRW-1:0] LINE_MASK = IADDRW'(IDATAW / 8 - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [2:0]                    r_issue_cnt;
    logic [2:0]                    r_rcv_cnt;
    logic [BEATS-1:0][MDATAW-1:0]  r_line;
    logic [IADDRW-1:0]             r_mem_address;

    logic              w_accept;
    logic              w_issue;
    logic              w_issue_last;
    logic              w_capture;
    logic              w_line_done;
    logic [IADDRW-1:0] w_base;

    assign w_accept     = req_valid & req_ready;
    assign w_issue      = mem_rd_en & mem_ready;
    assign w_issue_last = w_issue & (r_issue_cnt == LAST_BEAT);
    // Returns only count while a line is being built; stale beats are dropped.
    assign w_capture    = mem_rd_valid & ((r_state == S_ISSUE) | (r_state == S_WAIT));
    assign w_line_done  = w_capture & (r_rcv_cnt == LAST_BEAT);
    assign w_base       = req_address & ~LINE_MASK;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_ISSUE;
            S_ISSUE: begin
                if (w_line_done)       w_state_nxt = S_HOLD;
                else if (w_issue_last) w_state_nxt = S_WAIT;
            end
            S_WAIT:  if (w_line_done) w_state_nxt = S_HOLD;
            S_HOLD:  if (dp_ready)    w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        dp_valid  = 1'b0;
        mem_rd_en = 1'b0;
        busy      = 1'b0;
        case (r_state)
            S_IDLE:  req_ready = reset;
            S_ISSUE: begin
                mem_rd_en = 1'b1;
                busy      = 1'b1;
            end
            S_WAIT:  busy = 1'b1;
            S_HOLD:  begin
                dp_valid = 1'b1;
                busy     = 1'b1;
            end
            default: ;
        endcase
    end

    // The beat address advances only on acceptance and parks on the last beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_issue_cnt   <= '0;
            r_rcv_cnt     <= '0;
            r_line        <= '0;
            r_mem_address <= '0;
        end else if (w_accept) begin
            r_issue_cnt   <= '0;
            r_rcv_cnt     <= '0;
            r_mem_address <= w_base;
        end else begin
            if (w_issue) begin
                r_issue_cnt <= r_issue_cnt + 3'd1;
                if (!w_issue_last) begin
                    r_mem_address <= r_mem_address + IADDRW'(BEAT_BYTES);
                end
            end
            if (w_capture) begin
                r_line[r_rcv_cnt[SLOTW-1:0]] <= mem_rd_data;
                r_rcv_cnt                    <= r_rcv_cnt + 3'd1;
            end
        end
    end

    assign mem_address  = r_mem_address;
    assign dp_read_data = r_line;

endmodule

// File: tb/tb_imem_line_assembler.sv
// Directed-plus-random bench for imem_line_assembler with a behavioural
// memory responder and a line-level reference model.
module tb_imem_line_assembler;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_address;
    logic         dp_valid;
    logic         dp_ready;
    logic [127:0] dp_read_data;
    logic         mem_rd_en;
    logic         mem_ready;
    logic [31:0]  mem_address;
    logic         mem_rd_valid;
    logic [31:0]  mem_rd_data;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] salt;
    int          ready_mode;
    int          ret_mode;
    logic [31:0] pend_q[$];
    logic [31:0] issued_q[$];
    logic        stalled;
    logic [31:0] stall_addr;
    int          hold_viol;

    imem_line_assembler #(
        .IADDRW(32),
        .IDATAW(128),
        .MDATAW(32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_address (req_address),
        .dp_valid    (dp_valid),
        .dp_ready    (dp_ready),
        .dp_read_data(dp_read_data),
        .mem_rd_en   (mem_rd_en),
        .mem_ready   (mem_ready),
        .mem_address (mem_address),
        .mem_rd_valid(mem_rd_valid),
        .mem_rd_data (mem_rd_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] memval(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ salt;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: log accepted beats, advance, then drive the memory side.
    task automatic cycle();
        if (mem_rd_en && mem_ready) begin
            pend_q.push_back(mem_address);
            issued_q.push_back(mem_address);
        end
        stalled    = mem_rd_en && !mem_ready;
        stall_addr = mem_address;
        @(posedge clk);
        #1;
        cyc++;
        if (stalled && mem_rd_en && mem_address !== stall_addr) hold_viol++;
        case (ready_mode)
            0:       mem_ready = 1'b1;
            1:       mem_ready = 1'(cyc % 2);
            default: mem_ready = 1'($urandom_range(0, 1));
        endcase
        if (pend_q.size() > 0 && (ret_mode == 0 || $urandom_range(0, 2) != 0)) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = memval(pend_q.pop_front());
        end else begin
            mem_rd_valid = 1'b0;
            mem_rd_data  = $urandom;
        end
    endtask

    task automatic run_line(input logic [31:0] addr, input int rm, input int tm,
                            input int stall, input bit lat, input string tag);
        logic [31:0]  base;
        logic [127:0] exp_line;
        logic [127:0] held;
        base       = addr & ~32'hF;
        salt       = $urandom;
        ready_mode = rm;
        ret_mode   = tm;
        issued_q.delete();
        hold_viol  = 0;
        dp_ready   = 1'b0;
        for (int k = 0; k < 20 && !req_ready; k++) cycle();
        check({tag, "_req_ready"}, 128'(req_ready), 128'(1'b1));
        mem_ready   = (rm == 1) ? 1'b0 : 1'b1;
        req_valid   = 1'b1;
        req_address = addr;
        cycle();
        req_valid   = 1'b0;
        req_address = $urandom;
        if (lat) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("%s_addr%0d", tag, i), 128'(mem_address), 128'(base + 32'(4 * i)));
                check($sformatf("%s_en%0d", tag, i), 128'(mem_rd_en), 128'(1'b1));
                cycle();
            end
            check({tag, "_dpv_t5"}, 128'(dp_valid), 128'(1'b0));
            cycle();
            check({tag, "_dpv_t6"}, 128'(dp_valid), 128'(1'b1));
        end else begin
            for (int k = 0; k < 300 && !dp_valid; k++) cycle();
            check({tag, "_dpv"}, 128'(dp_valid), 128'(1'b1));
        end
        exp_line = {memval(base + 32'd12), memval(base + 32'd8), memval(base + 32'd4), memval(base)};
        check({tag, "_data"}, dp_read_data, exp_line);
        check({tag, "_nbeats"}, 128'(issued_q.size()), 128'(4));
        if (issued_q.size() == 4) begin
            for (int i = 0; i < 4; i++)
                check($sformatf("%s_beat%0d", tag, i), 128'(issued_q[i]), 128'(base + 32'(4 * i)));
        end
        check({tag, "_hold"}, 128'(hold_viol), 128'(0));
        held = dp_read_data;
        for (int i = 0; i < stall; i++) begin
            cycle();
            check($sformatf("%s_stall_dpv%0d", tag, i), 128'(dp_valid), 128'(1'b1));
            check($sformatf("%s_stall_data%0d", tag, i), dp_read_data, held);
            check($sformatf("%s_stall_rdy%0d", tag, i), 128'(req_ready), 128'(1'b0));
        end
        dp_ready = 1'b1;
        cycle();
        dp_ready = 1'b0;
        check({tag, "_idle_busy"}, 128'(busy), 128'(1'b0));
        check({tag, "_idle_rdy"}, 128'(req_ready), 128'(1'b1));
        check({tag, "_idle_dpv"}, 128'(dp_valid), 128'(1'b0));
    endtask

    initial begin
        logic [127:0] line_before;
        reset        = 1'b0;
        req_valid    = 1'b0;
        req_address  = '0;
        dp_ready     = 1'b0;
        mem_ready    = 1'b0;
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
        ready_mode   = 0;
        ret_mode     = 0;
        salt         = '0;
        #2;
        check("rst_req_ready", 128'(req_ready), 128'(1'b0));
        check("rst_dp_valid", 128'(dp_valid), 128'(1'b0));
        check("rst_mem_rd_en", 128'(mem_rd_en), 128'(1'b0));
        check("rst_busy", 128'(busy), 128'(1'b0));
        check("rst_mem_address", 128'(mem_address), 128'(0));
        check("rst_line", dp_read_data, 128'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

        run_line(32'h0000_1234, 0, 0, 0, 1'b1, "base");
        run_line($urandom, 1, 0, 0, 1'b0, "bp");
        run_line($urandom, 0, 0, 5, 1'b0, "stall");
        run_line(32'hFFFF_FFFC, 0, 0, 0, 1'b1, "wrap");

        // Stray return while idle must not touch the held line.
        line_before  = dp_read_data;
        mem_rd_valid = 1'b1;
        mem_rd_data  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        mem_rd_valid = 1'b0;
        check("spur_line", dp_read_data, line_before);
        check("spur_busy", 128'(busy), 128'(1'b0));

        // Reset two beats into a line.
        salt        = $urandom;
        ready_mode  = 0;
        ret_mode    = 0;
        mem_ready   = 1'b1;
        req_valid   = 1'b1;
        req_address = 32'h0000_8000;
        cycle();
        req_valid = 1'b0;
        cycle();
        cycle();
        cycle();
        reset = 1'b0;
        #1;
        check("mrst_req_ready", 128'(req_ready), 128'(1'b0));
        check("mrst_dp_valid", 128'(dp_valid), 128'(1'b0));
        check("mrst_mem_rd_en", 128'(mem_rd_en), 128'(1'b0));
        check("mrst_busy", 128'(busy), 128'(1'b0));
        check("mrst_mem_address", 128'(mem_address), 128'(0));
        check("mrst_line", dp_read_data, 128'(0));
        cycle();
        reset = 1'b1;
        pend_q.delete();
        for (int i = 0; i < 2; i++) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = $urandom;
            @(posedge clk);
            #1;
        end
        mem_rd_valid = 1'b0;
        check("post_rst_line", dp_read_data, 128'(0));
        check("post_rst_busy", 128'(busy), 128'(1'b0));
        check("post_rst_rdy", 128'(req_ready), 128'(1'b1));
        run_line(32'h0000_4568, 0, 0, 0, 1'b1, "after_rst");

        for (int n = 0; n < 6; n++)
            run_line($urandom, 2, 1, int'($urandom_range(0, 3)), 1'b0, $sformatf("rnd%0d", n));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
